rs_issue_scheduler: RTL and testbench

- Age-ordered select controller for the reservation station (RS).
- Tracks the allocation order of RS entries and picks the oldest entry whose operands are ready.
- Presents that entry to EX through a registered valid/ready handshake and reports occupancy and a free slot back to issue.
- Sits between the RS storage array, the issue stage and the ALU. Branch clear flushes it.

---
 rtl/rs_sched_pkg.sv | 22 ++
 rtl/rs_age_matrix.sv | 40 ++++
 rtl/rs_issue_scheduler.sv | 98 +++++++++
 tb/tb_rs_issue_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_sched_pkg.sv
// Shared sizing, types and helpers for the reservation-station issue scheduler.
package rs_sched_pkg;

  localparam int RS_SIZE = 16;
  localparam int IDX_W   = $clog2(RS_SIZE);
  localparam int CNT_W   = IDX_W + 1;

  typedef logic [RS_SIZE-1:0] rs_vec_t;
  typedef logic [IDX_W-1:0]   rs_idx_t;
  typedef logic [CNT_W-1:0]   rs_cnt_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic rs_idx_t lowest_set(input rs_vec_t v);
    rs_idx_t idx;
    idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (v[i]) idx = rs_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Allocation-order matrix: older[i][j] = 1 when entry i was allocated before entry j.
// Selects the single oldest eligible entry as a one-hot pick.
module rs_age_matrix
  import rs_sched_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    alloc_we,
  input  rs_idx_t alloc_idx,
  input  rs_vec_t elig,
  output rs_vec_t pick,
  output logic    any
);

  rs_vec_t older [RS_SIZE];

  // A new entry is younger than everything: its row is cleared and its column set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
    end else if (alloc_we) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (rs_idx_t'(j) == alloc_idx) older[j] <= '0;
        else                           older[j][alloc_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    pick = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      pick[i] = elig[i];
      for (int j = 0; j < RS_SIZE; j++) begin
        pick[i] = pick[i] & ~(elig[j] & older[j][i]);
      end
    end
    any = |elig;
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Age-ordered select for the reservation station: presents the oldest ready entry to EX
// through a registered valid/ready handshake and tracks occupancy and a free slot.
module rs_issue_scheduler
  import rs_sched_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               alloc_en_in,
  input  logic [IDX_W-1:0]   alloc_idx_in,
  input  logic [RS_SIZE-1:0] busy_vec_in,
  input  logic [RS_SIZE-1:0] ready_vec_in,
  input  logic               ex_ready_in,
  input  logic               clear_branch_in,
  output logic               free_valid_out,
  output logic [IDX_W-1:0]   free_idx_out,
  output logic               full_out,
  output logic [CNT_W-1:0]   occ_cnt_out,
  output logic               grant_valid_out,
  output logic [IDX_W-1:0]   grant_idx_out,
  output logic [RS_SIZE-1:0] grant_onehot_out
);

  rs_vec_t issued;
  rs_vec_t issued_next;
  rs_vec_t elig;
  rs_vec_t pick;
  rs_vec_t alloc_mask;
  logic    pick_any;
  logic    hs;
  logic    load;
  logic    alloc_we;
  rs_cnt_t occ_next;

  assign hs       = grant_valid_out & ex_ready_in;
  assign load     = ~grant_valid_out | hs;
  assign alloc_we = rdy_in & alloc_en_in & ~clear_branch_in;
  assign elig     = busy_vec_in & ready_vec_in & ~issued;
  assign occ_next = occ_cnt_out + rs_cnt_t'(alloc_en_in) - rs_cnt_t'(hs);

  assign free_valid_out = ~&busy_vec_in;
  assign free_idx_out   = lowest_set(~busy_vec_in);

  always_comb begin
    alloc_mask = '0;
    if (alloc_en_in) alloc_mask[alloc_idx_in] = 1'b1;
    issued_next = (issued & ~alloc_mask) | (load ? pick : '0);
  end

  rs_age_matrix u_age (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .alloc_we  (alloc_we),
    .alloc_idx (alloc_idx_in),
    .elig      (elig),
    .pick      (pick),
    .any       (pick_any)
  );

  // Clear wins over alloc/handshake; the presented grant holds until EX takes it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      grant_valid_out  <= 1'b0;
      grant_idx_out    <= '0;
      grant_onehot_out <= '0;
      issued           <= '0;
      occ_cnt_out      <= '0;
      full_out         <= 1'b0;
    end else if (rdy_in) begin
      if (clear_branch_in) begin
        grant_valid_out  <= 1'b0;
        grant_onehot_out <= '0;
        issued           <= '0;
        occ_cnt_out      <= '0;
        full_out         <= 1'b0;
      end else begin
        issued      <= issued_next;
        occ_cnt_out <= occ_next;
        full_out    <= (occ_next == rs_cnt_t'(RS_SIZE));
        if (load) begin
          grant_valid_out  <= pick_any;
          grant_idx_out    <= lowest_set(pick);
          grant_onehot_out <= pick;
        end
      end
    end
  end

  a_alloc_slot_free: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    alloc_we |-> (!busy_vec_in[alloc_idx_in] && !(grant_valid_out && grant_onehot_out[alloc_idx_in])));

  a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (alloc_we && !hs) |-> (occ_cnt_out != rs_cnt_t'(RS_SIZE)));

  a_no_underflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (rdy_in && !clear_branch_in && hs && !alloc_en_in) |-> (occ_cnt_out != '0));

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed table-driven bench for rs_issue_scheduler, with a small RS busy-bit model
// and hand-written sequences for async reset.
module tb_rs_issue_scheduler;
  import rs_sched_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          rdy;
  logic          alloc_en;
  rs_idx_t       alloc_idx;
  rs_vec_t       busy_vec;
  rs_vec_t       ready_vec;
  logic          ex_ready;
  logic          clear_branch;
  logic          free_valid;
  rs_idx_t       free_idx;
  logic          full;
  rs_cnt_t       occ_cnt;
  logic          grant_valid;
  rs_idx_t       grant_idx;
  rs_vec_t       grant_onehot;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic    rdy;
    logic    alloc_en;
    rs_idx_t alloc_idx;
    rs_vec_t ready;
    logic    ex_ready;
    logic    clear;
    logic    exp_gv;
    rs_idx_t exp_gidx;
    rs_cnt_t exp_occ;
    logic    exp_full;
    logic    chk_free;
    logic    exp_fv;
    rs_idx_t exp_fi;
  } vec_t;

  vec_t vecs [128];
  int   n_vec = 0;

  rs_issue_scheduler dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .rdy_in           (rdy),
    .alloc_en_in      (alloc_en),
    .alloc_idx_in     (alloc_idx),
    .busy_vec_in      (busy_vec),
    .ready_vec_in     (ready_vec),
    .ex_ready_in      (ex_ready),
    .clear_branch_in  (clear_branch),
    .free_valid_out   (free_valid),
    .free_idx_out     (free_idx),
    .full_out         (full),
    .occ_cnt_out      (occ_cnt),
    .grant_valid_out  (grant_valid),
    .grant_idx_out    (grant_idx),
    .grant_onehot_out (grant_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RS storage model: busy set on alloc, freed on handshake, flushed on clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else if (rdy) begin
      if (clear_branch) busy_vec <= '0;
      else begin
        busy_vec <= (busy_vec | ((alloc_en ? rs_vec_t'(1) : '0) << alloc_idx))
                    & ~((grant_valid && ex_ready) ? grant_onehot : '0);
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic row(input logic r, input logic ae, input int ai, input rs_vec_t rv,
                     input logic er, input logic cl, input logic gv, input int gi,
                     input int oc, input logic fu);
    vecs[n_vec] = '{rdy: r, alloc_en: ae, alloc_idx: rs_idx_t'(ai), ready: rv,
                    ex_ready: er, clear: cl, exp_gv: gv, exp_gidx: rs_idx_t'(gi),
                    exp_occ: rs_cnt_t'(oc), exp_full: fu, chk_free: 1'b0,
                    exp_fv: 1'b0, exp_fi: '0};
    n_vec++;
  endtask

  task automatic expect_free(input logic fv, input int fi);
    vecs[n_vec-1].chk_free = 1'b1;
    vecs[n_vec-1].exp_fv   = fv;
    vecs[n_vec-1].exp_fi   = rs_idx_t'(fi);
  endtask

  task automatic apply_stimulus(input vec_t v, input int n);
    rs_vec_t exp_oh;
    @(negedge clk);
    rdy          = v.rdy;
    alloc_en     = v.alloc_en;
    alloc_idx    = v.alloc_idx;
    ready_vec    = v.ready;
    ex_ready     = v.ex_ready;
    clear_branch = v.clear;
    @(posedge clk);
    #1;
    exp_oh = v.exp_gv ? (rs_vec_t'(1) << v.exp_gidx) : '0;
    check_output($sformatf("v%0d grant_valid", n), 32'(grant_valid), 32'(v.exp_gv));
    if (v.exp_gv)
      check_output($sformatf("v%0d grant_idx", n), 32'(grant_idx), 32'(v.exp_gidx));
    check_output($sformatf("v%0d grant_onehot", n), 32'(grant_onehot), 32'(exp_oh));
    check_output($sformatf("v%0d occ_cnt", n), 32'(occ_cnt), 32'(v.exp_occ));
    check_output($sformatf("v%0d full", n), 32'(full), 32'(v.exp_full));
    if (v.chk_free) begin
      check_output($sformatf("v%0d free_valid", n), 32'(free_valid), 32'(v.exp_fv));
      check_output($sformatf("v%0d free_idx", n), 32'(free_idx), 32'(v.exp_fi));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " grant_valid"}, 32'(grant_valid), 32'd0);
    check_output({tag, " grant_idx"}, 32'(grant_idx), 32'd0);
    check_output({tag, " grant_onehot"}, 32'(grant_onehot), 32'd0);
    check_output({tag, " occ_cnt"}, 32'(occ_cnt), 32'd0);
    check_output({tag, " full"}, 32'(full), 32'd0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; rdy = 1'b1; alloc_en = 1'b0; alloc_idx = '0;
    ready_vec = '0; ex_ready = 1'b0; clear_branch = 1'b0;

    // Three allocs, all ready together: dispatch in allocation order.
    row(1,1,5,16'h0000,1,0, 0,0,1,0); expect_free(1,0);
    row(1,1,2,16'h0000,1,0, 0,0,2,0);
    row(1,1,9,16'h0000,1,0, 0,0,3,0);
    row(1,0,0,16'h0224,1,0, 1,5,3,0);
    row(1,0,0,16'h0224,1,0, 1,2,2,0);
    row(1,0,0,16'h0224,1,0, 1,9,1,0);
    row(1,0,0,16'h0224,1,0, 0,0,0,0); expect_free(1,0);
    // Stalled grant on slot 3 while 7 waits.
    row(1,1,3,16'h0000,0,0, 0,0,1,0);
    row(1,1,7,16'h0000,0,0, 0,0,2,0);
    for (int i = 0; i < 4; i++) row(1,0,0,16'h0088,0,0, 1,3,2,0);
    row(1,0,0,16'h0088,1,0, 1,7,1,0);
    row(1,0,0,16'h0088,1,0, 0,0,0,0);
    // Age reorder: slot 0 re-allocated becomes younger than slot 1.
    row(1,1,1,16'h0000,1,0, 0,0,1,0);
    row(1,1,0,16'h0000,1,0, 0,0,2,0);
    row(1,0,0,16'h0001,1,0, 1,0,2,0);
    row(1,0,0,16'h0001,1,0, 0,0,1,0);
    row(1,1,0,16'h0000,1,0, 0,0,2,0);
    row(1,0,0,16'h0003,0,0, 1,1,2,0);
    row(1,0,0,16'h0003,1,0, 1,0,1,0);
    row(1,0,0,16'h0003,1,0, 0,0,0,0);
    // Fill all slots, free one, then alloc and handshake together.
    for (int i = 0; i < 16; i++) begin
      row(1,1,i,16'h0000,1,0, 0,0,i+1,(i == 15));
      if (i == 0)  expect_free(1,1);
      if (i == 15) expect_free(0,0);
    end
    row(1,0,0,16'h0010,0,0, 1,4,16,1);
    row(1,0,0,16'h0040,1,0, 1,6,15,0); expect_free(1,4);
    row(1,1,4,16'h0040,1,0, 0,0,15,0); expect_free(1,6);
    // Branch clear with occupancy 6 and a live grant; alloc/handshake ignored.
    row(1,0,0,16'h0000,0,1, 0,0,0,0); expect_free(1,0);
    for (int i = 0; i < 6; i++) row(1,1,i,16'h0000,0,0, 0,0,i+1,0);
    row(1,0,0,16'h0001,0,0, 1,0,6,0);
    row(1,1,10,16'h0001,1,1, 0,0,0,0); expect_free(1,0);
    row(1,1,2,16'h0000,0,0, 0,0,1,0);
    row(1,0,0,16'h0004,0,0, 1,2,1,0);
    // rdy low freezes everything, including alloc and a would-be handshake.
    for (int i = 0; i < 3; i++) row(0,1,8,16'h0004,1,0, 1,2,1,0);
    row(1,0,0,16'h0004,1,0, 0,0,0,0);
    row(1,1,3,16'h0000,0,0, 0,0,1,0);
    row(1,0,0,16'h0008,0,0, 1,3,1,0);

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int n = 0; n < n_vec; n++) apply_stimulus(vecs[n], n);

    // Asynchronous reset mid-dispatch, away from the clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    v = '{rdy: 1'b1, alloc_en: 1'b1, alloc_idx: 4'd5, ready: '0, ex_ready: 1'b1,
          clear: 1'b0, exp_gv: 1'b0, exp_gidx: '0, exp_occ: 5'd1, exp_full: 1'b0,
          chk_free: 1'b1, exp_fv: 1'b1, exp_fi: '0};
    apply_stimulus(v, 900);
    v.alloc_en = 1'b0; v.ready = 16'h0020; v.exp_gv = 1'b1; v.exp_gidx = 4'd5;
    v.chk_free = 1'b0;
    apply_stimulus(v, 901);
    v.exp_gv = 1'b0; v.exp_occ = 5'd0;
    apply_stimulus(v, 902);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
